seq_gen_lfsr: RTL and testbench

- Upstream stage of the game FSM: generates the random 4-colour (2-bit symbol) sequence the game displays and checks against player input.
- Free-running 16-bit Galois LFSR; game entropy comes from when the player presses start.
- On `start`, fills a DEPTH-entry symbol memory, one symbol per cycle, limiting consecutive repeats.
- Serves the game FSM through an indexed, registered read port.

---
 rtl/game_pkg.sv | 25 ++
 rtl/lfsr16.sv | 29 ++
 rtl/seq_gen_lfsr.sv | 103 ++++++++++
 tb/tb_seq_gen_lfsr.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, LFSR constants and symbol-to-LED mapping
package game_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READY
    } gen_state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One-hot LED pattern per colour symbol, shared with the game FSM
    localparam logic [3:0] LED_SYM0 = 4'b0001;
    localparam logic [3:0] LED_SYM1 = 4'b0010;
    localparam logic [3:0] LED_SYM2 = 4'b0100;
    localparam logic [3:0] LED_SYM3 = 4'b1000;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit right-shift Galois LFSR
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = lfsr_next(q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_gen_lfsr.sv
// rtl/seq_gen_lfsr.sv - fills a symbol memory from the LFSR on start, serves it by index
module seq_gen_lfsr
    import game_pkg::*;
#(
    parameter int          DEPTH      = 100,
    parameter int          IDX_W      = 7,
    parameter logic [15:0] SEED       = DEFAULT_SEED,
    parameter int          MAX_REPEAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_sym,
    output logic             ready,
    output logic             busy
);

    logic [15:0]      lfsr_val;
    gen_state_t       state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]       run_len_q, run_len_d;
    sym_t             prev_sym_q, prev_sym_d;
    sym_t             rd_sym_q, rd_sym_d;
    sym_t             raw;
    sym_t             sym;
    logic             override;
    logic             mem_we;
    sym_t             mem [DEPTH];

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_val)
    );

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        run_len_d  = run_len_q;
        prev_sym_d = prev_sym_q;
        mem_we     = 1'b0;
        raw        = lfsr_val[1:0];
        // Bump the symbol when it would extend a run already at the limit
        override   = (wr_idx_q != '0) && (raw == prev_sym_q)
                     && (run_len_q == 2'(MAX_REPEAT));
        sym        = override ? raw + 2'd1 : raw;

        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    state_d    = FILL;
                    wr_idx_d   = '0;
                    run_len_d  = '0;
                    prev_sym_d = '0;
                end
            end
            FILL: begin
                mem_we     = 1'b1;
                run_len_d  = ((wr_idx_q != '0) && (sym == prev_sym_q)) ? run_len_q + 2'd1 : 2'd1;
                prev_sym_d = sym;
                wr_idx_d   = wr_idx_q + 1'b1;
                if (wr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_sym_d = '0;
        if ((state_q == READY) && ({1'b0, rd_idx} < (IDX_W + 1)'(DEPTH))) begin
            rd_sym_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_idx_q   <= '0;
            run_len_q  <= '0;
            prev_sym_q <= '0;
            rd_sym_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            run_len_q  <= run_len_d;
            prev_sym_q <= prev_sym_d;
            rd_sym_q   <= rd_sym_d;
        end
    end

    // Storage is not reset; ready gates any stale contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx_q] <= sym;
        end
    end

    assign rd_sym = rd_sym_q;
    assign ready  = (state_q == READY);
    assign busy   = (state_q == FILL);

endmodule

// File: tb/tb_seq_gen_lfsr.sv
// tb/tb_seq_gen_lfsr.sv - scoreboard bench for seq_gen_lfsr, default and MAX_REPEAT=1 builds
module tb_seq_gen_lfsr;

    localparam int DEPTH = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] rd_idx = '0;
    logic [6:0] rd_idx1 = '0;
    logic [1:0] rd_sym, rd_sym1;
    logic       ready, busy, ready1, busy1;

    always #5 clk = ~clk;

    seq_gen_lfsr dut (
        .clk(clk), .rst(rst), .start(start), .rd_idx(rd_idx),
        .rd_sym(rd_sym), .ready(ready), .busy(busy)
    );

    seq_gen_lfsr #(.MAX_REPEAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .rd_idx(rd_idx1),
        .rd_sym(rd_sym1), .ready(ready1), .busy(busy1)
    );

    typedef struct {
        bit         sel;
        int         idx;
        logic [1:0] exp;
    } sb_t;

    sb_t        sb_q[$];
    sb_t        sb_e;
    logic [1:0] mon_act;
    logic [1:0] exp_seq[DEPTH];
    logic [1:0] act0[DEPTH];
    logic [1:0] act1[DEPTH];
    logic [15:0] lfsr_tab[5];
    logic [15:0] m_lfsr;
    logic [15:0] l0;
    bit         rd_vld = 1'b0;
    bit         mon_pend = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    // Reference LFSR tracking the free-running generator
    always @(posedge clk) begin
        mon_pend <= rd_vld;
        m_lfsr   <= rst ? 16'hACE1 : ((m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: output with no expected entry");
                end else begin
                    sb_e    = sb_q.pop_front();
                    mon_act = sb_e.sel ? rd_sym1 : rd_sym;
                    check($sformatf("rd_sym%s[%0d]", sb_e.sel ? "_mr1" : "", sb_e.idx),
                          int'(mon_act), int'(sb_e.exp));
                    if (sb_e.idx < DEPTH) begin
                        if (sb_e.sel) act1[sb_e.idx] = mon_act;
                        else          act0[sb_e.idx] = mon_act;
                    end
                end
            end
        end
    end

    task automatic gen_model(input logic [15:0] seed_v, input int maxrep);
        logic [15:0] l;
        logic [1:0]  prev, raw, s;
        int          run;
        l = seed_v; prev = 2'd0; run = 0;
        for (int i = 0; i < DEPTH; i++) begin
            raw = l[1:0];
            s   = (i > 0 && raw == prev && run == maxrep) ? raw + 2'd1 : raw;
            run = (i > 0 && s == prev) ? run + 1 : 1;
            prev = s;
            exp_seq[i] = s;
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    task automatic rd(input bit sel, input int idx, input logic [1:0] e);
        if (sel) rd_idx1 = 7'(idx);
        else     rd_idx  = 7'(idx);
        rd_vld = 1'b1;
        sb_q.push_back('{sel, idx, e});
        tick();
    endtask

    task automatic sweep(input bit sel);
        for (int i = 0; i < DEPTH; i++) rd(sel, i, exp_seq[i]);
    endtask

    task automatic drain();
        rd_vld = 1'b0;
        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic run_check(input bit sel, input int lim);
        int run, mx;
        logic [1:0] a, p;
        run = 0; mx = 0; p = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            a   = sel ? act1[i] : act0[i];
            run = (i > 0 && a == p) ? run + 1 : 1;
            if (run > mx) mx = run;
            p = a;
        end
        check($sformatf("max_run_le_%0d%s", lim, sel ? "_mr1" : ""), int'(mx <= lim), 1);
    endtask

    task automatic fill(input int hold, output logic [15:0] seed_o);
        int n;
        start = 1'b1;
        tick();
        seed_o = m_lfsr;
        check("fill_start_busy", busy, 1);
        check("fill_start_ready", ready, 0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n >= hold) start = 1'b0;
            tick();
        end
        start = 1'b0;
        check("fill_cycles", n, DEPTH);
        check("fill_done_ready", ready, 1);
        check("fill_done_ready_mr1", ready1, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        lfsr_tab = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) check($sformatf("lfsr[%0d]", i), int'(dut.lfsr_val), int'(lfsr_tab[i]));
            check("idle_ready", ready, 0);
            check("idle_busy", busy, 0);
            check("idle_rd_sym", int'(rd_sym), 0);
            tick();
        end

        // Start sampled on the first edge after reset release
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        fill(1, l0);
        check("first_fill_seed", int'(l0), 16'hE270);
        rd(0, 0, 2'd0);
        rd(0, 1, 2'd0);
        rd(0, 2, 2'd1);
        rd(0, 3, 2'd2);
        gen_model(16'hE270, 2);
        sweep(0);
        rd(0, 100, 2'd0);
        rd(0, 127, 2'd0);
        drain();
        run_check(0, 2);
        gen_model(16'hE270, 1);
        sweep(1);
        drain();
        run_check(1, 1);

        // Regenerate from READY with start held well into the fill
        fill(30, l0);
        gen_model(l0, 2);
        sweep(0);
        drain();

        // Reset in the middle of a fill
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check("mid_wr_idx", int'(dut.wr_idx_q), 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ready", ready, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        check("rst_mid_stays_idle", busy, 0);
        rd(0, 5, 2'd0);
        drain();

        fill(1, l0);
        gen_model(l0, 2);
        sweep(0);
        drain();
        run_check(0, 2);
        gen_model(l0, 1);
        sweep(1);
        drain();
        run_check(1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
